// File: rtl/temp_servo_ramp_seq_if.sv
// Signal bundle for the multi-channel temperature servo ramp sequencer.
// The master side drives the run requests, the errors and the ramp settings; the slave side drives the status outputs.
interface temp_servo_ramp_seq_if #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned SIGSIZE = 18,
  parameter int unsigned FRAC    = 24,
  parameter int unsigned TW      = 32
);
  logic [NCH-1:0]          on;
  logic [NCH*SIGSIZE-1:0]  err;
  logic [NCH*SIGSIZE-1:0]  prst_max;
  logic [SIGSIZE+FRAC-1:0] step;
  logic [TW-1:0]           dwell_max;
  logic [NCH-1:0]          PID_EN;
  logic [NCH*SIGSIZE-1:0]  prst;
  logic [NCH*3-1:0]        state;
  logic [NCH-1:0]          fault;

  modport master (
    output on, err, prst_max, step, dwell_max,
    input  PID_EN, prst, state, fault
  );

  modport slave (
    input  on, err, prst_max, step, dwell_max,
    output PID_EN, prst, state, fault
  );
endinterface

// File: rtl/temp_servo_ramp_seq.sv
// Multi-channel temperature servo preset ramp sequencer.
// Each channel ramps its preset toward a target and hands control to the PID once the error changes sign.
module temp_servo_ramp_seq #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned SIGSIZE = 18,
  parameter int unsigned FRAC    = 24,
  parameter int unsigned TW      = 32,
  parameter int unsigned ONATMAX = 0
) (
  input logic                  clk,
  input logic                  rst,
  temp_servo_ramp_seq_if.slave bus
);
  localparam int unsigned SW = SIGSIZE + FRAC;
  localparam int unsigned AW = SW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    WAIT  = 3'd2,
    LOCK  = 3'd3,
    DOWN  = 3'd4,
    FAULT = 3'd5
  } st_e;

  st_e                st_q    [NCH];
  st_e                st_d    [NCH];
  logic [AW-1:0]      acc_q   [NCH];
  logic [AW-1:0]      acc_d   [NCH];
  logic [AW-1:0]      tgt     [NCH];
  logic [AW-1:0]      up      [NCH];
  logic [AW-1:0]      dn      [NCH];
  logic [AW-1:0]      trk     [NCH];
  logic [AW:0]        sum     [NCH];
  logic [SIGSIZE-1:0] pm      [NCH];
  logic [SIGSIZE-1:0] prst_q  [NCH];
  logic [TW-1:0]      cnt_q   [NCH];
  logic [TW-1:0]      cnt_d   [NCH];
  logic [TW-1:0]      cnt_inc [NCH];
  logic [NCH-1:0]     sgn0_q, sgn1_q, flip, pid_q, flt_q;
  logic [AW-1:0]      step_eff;

  // A negative target or step is treated as zero.
  always_comb begin
    step_eff = bus.step[SW-1] ? '0 : {1'b0, bus.step};
    flip     = sgn0_q ^ sgn1_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      pm[i]      = bus.prst_max[i*SIGSIZE +: SIGSIZE];
      tgt[i]     = pm[i][SIGSIZE-1] ? '0 : {1'b0, pm[i], {FRAC{1'b0}}};
      sum[i]     = {1'b0, acc_q[i]} + {1'b0, step_eff};
      up[i]      = (sum[i] >= {1'b0, tgt[i]}) ? tgt[i] : sum[i][AW-1:0];
      dn[i]      = (acc_q[i] <= step_eff) ? '0 : acc_q[i] - step_eff;
      cnt_inc[i] = cnt_q[i] + TW'(1);
      if (acc_q[i] <= tgt[i])
        trk[i] = up[i];
      else if (acc_q[i] - tgt[i] <= step_eff)
        trk[i] = tgt[i];
      else
        trk[i] = dn[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      acc_d[i] = acc_q[i];
      cnt_d[i] = '0;
      case (st_q[i])
        IDLE: begin
          acc_d[i] = '0;
          if (bus.on[i]) st_d[i] = RAMP;
        end
        RAMP: begin
          if (!bus.on[i]) st_d[i] = DOWN;
          else begin
            acc_d[i] = up[i];
            if (flip[i])              st_d[i] = LOCK;
            else if (up[i] == tgt[i]) st_d[i] = (ONATMAX != 0) ? LOCK : WAIT;
          end
        end
        WAIT: begin
          if (!bus.on[i]) st_d[i] = DOWN;
          else begin
            acc_d[i] = trk[i];
            if (flip[i]) st_d[i] = LOCK;
            else if (bus.dwell_max != '0 && cnt_inc[i] == bus.dwell_max) begin
              st_d[i]  = FAULT;
              acc_d[i] = '0;
            end else cnt_d[i] = cnt_inc[i];
          end
        end
        LOCK: begin
          if (!bus.on[i]) st_d[i] = DOWN;
          else            acc_d[i] = up[i];
        end
        // Re-enabling while ramping down resumes from the present preset.
        DOWN: begin
          if (bus.on[i]) st_d[i] = RAMP;
          else begin
            acc_d[i] = dn[i];
            if (dn[i] == '0) st_d[i] = IDLE;
          end
        end
        FAULT: begin
          acc_d[i] = '0;
          if (!bus.on[i]) st_d[i] = IDLE;
        end
        default: begin
          st_d[i]  = IDLE;
          acc_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn0_q <= '0;
      sgn1_q <= '0;
      pid_q  <= '0;
      flt_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]   <= IDLE;
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
        prst_q[i] <= '0;
      end
    end else begin
      sgn1_q <= sgn0_q;
      for (int unsigned i = 0; i < NCH; i++) begin
        st_q[i]   <= st_d[i];
        acc_q[i]  <= acc_d[i];
        cnt_q[i]  <= cnt_d[i];
        prst_q[i] <= acc_q[i][SW-1:FRAC];
        sgn0_q[i] <= bus.err[i*SIGSIZE + SIGSIZE - 1];
        pid_q[i]  <= (st_d[i] == LOCK);
        flt_q[i]  <= (st_d[i] == FAULT);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign bus.prst[g*SIGSIZE +: SIGSIZE] = prst_q[g];
    assign bus.state[g*3 +: 3]            = st_q[g];
  end
  assign bus.PID_EN = pid_q;
  assign bus.fault  = flt_q;
endmodule

// File: tb/tb_temp_servo_ramp_seq.sv
// Bench for temp_servo_ramp_seq: two instances (hand-over on sign flip only, and hand-over on reaching target)
// share the same stimulus and are compared every cycle against a behavioural model.
module tb_temp_servo_ramp_seq;
  localparam int SS = 18;
  localparam int FR = 24;

  logic               clk;
  logic               rst;
  logic [1:0]         on_v;
  int                 err_v [2];
  int                 pm_v  [2];
  logic signed [41:0] step_v;
  logic [31:0]        dwell_v;

  int checks = 0;
  int errors = 0;

  temp_servo_ramp_seq_if #(.NCH(2), .SIGSIZE(SS), .FRAC(FR), .TW(32)) if0 ();
  temp_servo_ramp_seq_if #(.NCH(2), .SIGSIZE(SS), .FRAC(FR), .TW(32)) if1 ();

  temp_servo_ramp_seq #(.NCH(2), .SIGSIZE(SS), .FRAC(FR), .TW(32), .ONATMAX(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  temp_servo_ramp_seq #(.NCH(2), .SIGSIZE(SS), .FRAC(FR), .TW(32), .ONATMAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  assign if0.on        = on_v;
  assign if1.on        = on_v;
  assign if0.err       = {18'(err_v[1]), 18'(err_v[0])};
  assign if1.err       = {18'(err_v[1]), 18'(err_v[0])};
  assign if0.prst_max  = {18'(pm_v[1]), 18'(pm_v[0])};
  assign if1.prst_max  = {18'(pm_v[1]), 18'(pm_v[0])};
  assign if0.step      = step_v;
  assign if1.step      = step_v;
  assign if0.dwell_max = dwell_v;
  assign if1.dwell_max = dwell_v;

  logic [2:0]  st_o  [2][2];
  logic [17:0] pr_o  [2][2];
  logic        pid_o [2][2];
  logic        flt_o [2][2];
  for (genvar c = 0; c < 2; c++) begin : g_obs
    assign st_o[0][c]  = if0.state[c*3 +: 3];
    assign st_o[1][c]  = if1.state[c*3 +: 3];
    assign pr_o[0][c]  = if0.prst[c*SS +: SS];
    assign pr_o[1][c]  = if1.prst[c*SS +: SS];
    assign pid_o[0][c] = if0.PID_EN[c];
    assign pid_o[1][c] = if1.PID_EN[c];
    assign flt_o[0][c] = if0.fault[c];
    assign flt_o[1][c] = if1.fault[c];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model, indexed [instance][channel]; instance 1 hands over on reaching target.
  int     mst  [2][2];
  longint macc [2][2];
  longint mprst[2][2];
  longint mcnt [2][2];
  bit     ms0  [2][2];
  bit     ms1  [2][2];

  function automatic longint toward(input longint a, input longint g, input longint s);
    if (a < g) return (a + s < g) ? a + s : g;
    return (a - s > g) ? a - s : g;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        mst[d][c] = 0; macc[d][c] = 0; mprst[d][c] = 0;
        mcnt[d][c] = 0; ms0[d][c] = 0; ms1[d][c] = 0;
      end
  endtask

  task automatic model_step();
    longint stp, tgt, acc, up, nacc;
    int     nst;
    bit     flp;
    stp = (step_v > 0) ? longint'(step_v) : 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        tgt  = (pm_v[c] > 0) ? (longint'(pm_v[c]) << FR) : 0;
        acc  = macc[d][c];
        flp  = (ms0[d][c] != ms1[d][c]);
        up   = (acc + stp < tgt) ? acc + stp : tgt;
        nacc = acc;
        nst  = mst[d][c];
        case (mst[d][c])
          0: begin nacc = 0; if (on_v[c]) nst = 1; end
          1: if (!on_v[c]) nst = 4;
             else begin
               nacc = up;
               if (flp) nst = 3;
               else if (up == tgt) nst = (d == 1) ? 3 : 2;
             end
          2: if (!on_v[c]) nst = 4;
             else begin
               nacc = toward(acc, tgt, stp);
               if (flp) nst = 3;
               else if (dwell_v != 0 && mcnt[d][c] + 1 == longint'(dwell_v)) begin
                 nst = 5; nacc = 0;
               end
             end
          3: if (!on_v[c]) nst = 4; else nacc = up;
          4: if (on_v[c]) nst = 1;
             else begin
               nacc = toward(acc, 0, stp);
               if (nacc == 0) nst = 0;
             end
          default: begin nacc = 0; if (!on_v[c]) nst = 0; end
        endcase
        mcnt[d][c]  = (mst[d][c] == 2 && nst == 2) ? mcnt[d][c] + 1 : 0;
        mprst[d][c] = acc >> FR;
        macc[d][c]  = nacc;
        mst[d][c]   = nst;
        ms1[d][c]   = ms0[d][c];
        ms0[d][c]   = (err_v[c] < 0);
      end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("model.d%0d.c%0d.state", d, c), longint'(st_o[d][c]), mst[d][c]);
        chk($sformatf("model.d%0d.c%0d.prst", d, c), longint'(pr_o[d][c]), mprst[d][c]);
        chk($sformatf("model.d%0d.c%0d.pid", d, c), longint'(pid_o[d][c]), (mst[d][c] == 3) ? 1 : 0);
        chk($sformatf("model.d%0d.c%0d.fault", d, c), longint'(flt_o[d][c]), (mst[d][c] == 5) ? 1 : 0);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset between edges and checks the outputs clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("rst.d%0d.c%0d.state", d, c), longint'(st_o[d][c]), 0);
        chk($sformatf("rst.d%0d.c%0d.prst", d, c), longint'(pr_o[d][c]), 0);
        chk($sformatf("rst.d%0d.c%0d.pid", d, c), longint'(pid_o[d][c]), 0);
        chk($sformatf("rst.d%0d.c%0d.fault", d, c), longint'(flt_o[d][c]), 0);
      end
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit on0;
    int err0;
    int cyc;
    int est;
    int eprst;
    bit epid;
    bit eflt;
  } vec_t;

  vec_t   tbl [16];
  longint step_tab [7];
  int     dwell_tab [4];

  initial begin
    tbl[0]  = '{1,  100,  1, 1,  0, 0, 0};
    tbl[1]  = '{1,  100,  3, 1,  2, 0, 0};
    tbl[2]  = '{1,  100,  7, 2,  9, 0, 0};
    tbl[3]  = '{1,  100,  1, 2, 10, 0, 0};
    tbl[4]  = '{1,  100, 20, 2, 10, 0, 0};
    tbl[5]  = '{0,  100,  1, 4, 10, 0, 0};
    tbl[6]  = '{0,  100,  5, 4,  6, 0, 0};
    tbl[7]  = '{1,  100,  1, 1,  5, 0, 0};
    tbl[8]  = '{1,  100,  1, 1,  5, 0, 0};
    tbl[9]  = '{1, -100,  1, 1,  6, 0, 0};
    tbl[10] = '{1, -100,  1, 3,  7, 1, 0};
    tbl[11] = '{1, -100,  1, 3,  8, 1, 0};
    tbl[12] = '{1, -100,  3, 3, 10, 1, 0};
    tbl[13] = '{0, -100,  1, 4, 10, 0, 0};
    tbl[14] = '{0, -100, 11, 0,  0, 0, 0};
    tbl[15] = '{0,  100,  2, 0,  0, 0, 0};
    step_tab  = '{64'd1 << 24, 64'd3 << 23, 64'd7 << 22, 64'd1 << 25, 0, -(64'sd1 << 24), 64'd5 << 21};
    dwell_tab = '{0, 3, 10, 40};

    rst = 1'b1;
    on_v = 2'b00;
    err_v = '{100, 100};
    pm_v = '{10, 10};
    step_v = 42'sd16777216;
    dwell_v = 32'd0;
    model_reset();
    do_reset();

    for (int r = 0; r < 16; r++) begin
      on_v[0]  = tbl[r].on0;
      err_v[0] = tbl[r].err0;
      repeat (tbl[r].cyc) tick();
      chk($sformatf("tbl%0d.state", r), longint'(st_o[0][0]), tbl[r].est);
      chk($sformatf("tbl%0d.prst", r), longint'(pr_o[0][0]), tbl[r].eprst);
      chk($sformatf("tbl%0d.pid", r), longint'(pid_o[0][0]), tbl[r].epid);
      chk($sformatf("tbl%0d.fault", r), longint'(flt_o[0][0]), tbl[r].eflt);
      chk($sformatf("tbl%0d.ch1_state", r), longint'(st_o[0][1]), 0);
      chk($sformatf("tbl%0d.ch1_prst", r), longint'(pr_o[0][1]), 0);
    end

    // Dwell timeout, and the target-reached hand-over on the second instance.
    do_reset();
    err_v = '{100, 100};
    dwell_v = 32'd100;
    on_v[0] = 1'b1;
    repeat (11) tick();
    chk("dwell.wait_entry", longint'(st_o[0][0]), 2);
    chk("onatmax.state", longint'(st_o[1][0]), 3);
    chk("onatmax.pid", longint'(pid_o[1][0]), 1);
    chk("onatmax.prst", longint'(pr_o[1][0]), 9);
    repeat (99) tick();
    chk("dwell.before_state", longint'(st_o[0][0]), 2);
    chk("dwell.before_fault", longint'(flt_o[0][0]), 0);
    tick();
    chk("dwell.fault_state", longint'(st_o[0][0]), 5);
    chk("dwell.fault_flag", longint'(flt_o[0][0]), 1);
    tick();
    chk("dwell.prst_zero", longint'(pr_o[0][0]), 0);
    on_v[0] = 1'b0;
    tick();
    chk("dwell.clear_state", longint'(st_o[0][0]), 0);
    chk("dwell.clear_fault", longint'(flt_o[0][0]), 0);

    // Reset applied mid-ramp, away from any clock edge.
    dwell_v = 32'd0;
    on_v = 2'b11;
    repeat (5) tick();
    chk("async.pre_prst", longint'(pr_o[0][0]), 3);
    #2;
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) on_v[$urandom_range(1)] ^= 1'b1;
      for (int c = 0; c < 2; c++)
        if ($urandom_range(7) == 0) err_v[c] = -err_v[c];
      if ($urandom_range(39) == 0) pm_v[$urandom_range(1)] = int'($urandom_range(33)) - 3;
      if ($urandom_range(49) == 0) step_v = 42'(step_tab[$urandom_range(6)]);
      if ($urandom_range(99) == 0) dwell_v = 32'(dwell_tab[$urandom_range(3)]);
      if ($urandom_range(499) == 0) do_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
